// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, sequencer FSM state encoding
// and a helper to classify arithmetic opcodes.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [OP_W-1:0] ALU_NOT = 3'b101;
  localparam logic [OP_W-1:0] ALU_LSH = 3'b110;
  localparam logic [OP_W-1:0] ALU_RSH = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Only ADD and SUB contribute to the sticky carry/overflow status.
  function automatic logic is_add_sub(input logic [OP_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_sticky_flags.sv
// Sticky carry/overflow status bits. A clear in the same cycle as a
// qualified update is applied first, so the result is just the new flag.
module alu_sticky_flags (
  input  logic clk,
  input  logic rst,
  input  logic update,
  input  logic qualify,
  input  logic clr,
  input  logic carry,
  input  logic ovf,
  output logic sticky_carry,
  output logic sticky_ovf
);

  logic [1:0] flag_in;
  logic [1:0] sticky_reg;
  logic [1:0] sticky_next;

  assign flag_in = {ovf, carry};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag
      assign sticky_next[gi] = (clr ? 1'b0 : sticky_reg[gi])
                             | (update & qualify & flag_in[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_reg <= '0;
    end else begin
      sticky_reg <= sticky_next;
    end
  end

  assign sticky_carry = sticky_reg[0];
  assign sticky_ovf   = sticky_reg[1];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer in front of the combinational alu: owns acc/b/op
// registers, captures alu result one cycle after issue, returns it on rsp.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int N       = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_load,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [N-1:0]       cmd_operand,
  output logic [N-1:0]       alu_a,
  output logic [N-1:0]       alu_b,
  output logic [OP_W-1:0]    alu_op,
  input  logic [N-1:0]       alu_result,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_overflow,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N-1:0]       rsp_result,
  output logic               rsp_zero,
  output logic               rsp_carry,
  output logic               rsp_overflow,
  input  logic               clr_sticky,
  output logic               sticky_carry,
  output logic               sticky_ovf,
  output logic [N-1:0]       acc,
  output logic [COUNT_W-1:0] op_count
);

  logic [1:0]         state_reg;
  logic [1:0]         state_next;
  logic [N-1:0]       acc_reg;
  logic [N-1:0]       b_reg;
  logic [OP_W-1:0]    op_reg;
  logic [N-1:0]       rsp_result_reg;
  logic               rsp_zero_reg;
  logic               rsp_carry_reg;
  logic               rsp_overflow_reg;
  logic [COUNT_W-1:0] op_count_reg;
  logic               accept;
  logic               in_exec;

  // Ready depends only on state and rsp_ready, never on cmd_*, so the
  // response channel has no combinational path from the command side.
  assign cmd_ready = (state_reg == S_IDLE) || ((state_reg == S_RESP) && rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign in_exec   = (state_reg == S_EXEC);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_RESP: begin
        if (accept) begin
          state_next = cmd_load ? S_RESP : S_EXEC;
        end else if ((state_reg == S_RESP) && rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      S_EXEC:  state_next = S_RESP;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      acc_reg          <= '0;
      b_reg            <= '0;
      op_reg           <= '0;
      rsp_result_reg   <= '0;
      rsp_zero_reg     <= 1'b0;
      rsp_carry_reg    <= 1'b0;
      rsp_overflow_reg <= 1'b0;
      op_count_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        if (cmd_load) begin
          acc_reg          <= cmd_operand;
          rsp_result_reg   <= cmd_operand;
          rsp_zero_reg     <= (cmd_operand == '0);
          rsp_carry_reg    <= 1'b0;
          rsp_overflow_reg <= 1'b0;
        end else begin
          b_reg  <= cmd_operand;
          op_reg <= cmd_op;
        end
      end
      // accept cannot coincide with EXEC because cmd_ready is low there.
      if (in_exec) begin
        acc_reg          <= alu_result;
        rsp_result_reg   <= alu_result;
        rsp_zero_reg     <= alu_zero;
        rsp_carry_reg    <= alu_carry;
        rsp_overflow_reg <= alu_overflow;
        op_count_reg     <= op_count_reg + COUNT_W'(1);
      end
    end
  end

  alu_sticky_flags u_sticky (
    .clk          (clk),
    .rst          (rst),
    .update       (in_exec),
    .qualify      (is_add_sub(op_reg)),
    .clr          (clr_sticky),
    .carry        (alu_carry),
    .ovf          (alu_overflow),
    .sticky_carry (sticky_carry),
    .sticky_ovf   (sticky_ovf)
  );

  assign alu_a        = acc_reg;
  assign alu_b        = b_reg;
  assign alu_op       = op_reg;
  assign acc          = acc_reg;
  assign rsp_valid    = (state_reg == S_RESP);
  assign rsp_result   = rsp_result_reg;
  assign rsp_zero     = rsp_zero_reg;
  assign rsp_carry    = rsp_carry_reg;
  assign rsp_overflow = rsp_overflow_reg;
  assign op_count     = op_count_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural 4-bit alu attached.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  localparam int N = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_load = 1'b0;
  logic [2:0]    cmd_op = 3'b000;
  logic [N-1:0]  cmd_operand = '0;
  logic [N-1:0]  alu_a, alu_b;
  logic [2:0]    alu_op;
  logic [N-1:0]  alu_result;
  logic          alu_zero, alu_carry, alu_overflow;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [N-1:0]  rsp_result;
  logic          rsp_zero, rsp_carry, rsp_overflow;
  logic          clr_sticky = 1'b0;
  logic          sticky_carry, sticky_ovf;
  logic [N-1:0]  acc;
  logic [CW-1:0] op_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] r;
    logic       z, c, o;
    int         cyc;
  } item_t;
  item_t sb[$];

  alu_seq_ctrl #(.N(N), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
    .clr_sticky(clr_sticky), .sticky_carry(sticky_carry), .sticky_ovf(sticky_ovf),
    .acc(acc), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural alu; SUB carry means borrow.
  always_comb begin
    logic [N:0] wide;
    wide         = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = wide[N-1:0];
        alu_carry    = wide[N];
        alu_overflow = (alu_a[N-1] == alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
      end
      ALU_SUB: begin
        alu_result   = alu_a - alu_b;
        alu_carry    = (alu_a < alu_b);
        alu_overflow = (alu_a[N-1] != alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
      end
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_NOT: alu_result = ~alu_a;
      ALU_LSH: begin alu_result = alu_a << 1; alu_carry = alu_a[N-1]; end
      default: begin alu_result = alu_a >> 1; alu_carry = alu_a[0]; end
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: first-valid latency, data held while valid, pop on handshake.
  initial begin
    bit seen = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        seen = 0;
      end else if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          if (!seen) chk("rsp_latency_cycle", cyc, sb[0].cyc);
          seen = 1;
          chk("rsp_data", {rsp_result, rsp_zero, rsp_carry, rsp_overflow},
              {sb[0].r, sb[0].z, sb[0].c, sb[0].o});
          if (rsp_ready) begin
            $display("rsp r=%b z=%b c=%b o=%b cycle=%0d", rsp_result, rsp_zero,
                     rsp_carry, rsp_overflow, cyc);
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  // Presents a command (caller is at a negedge), waits for acceptance,
  // queues the expected response. Returns at the negedge after accept.
  task automatic issue(input logic ld, input logic [2:0] op, input logic [3:0] opnd,
                       input logic [3:0] r, input logic z, input logic c, input logic o,
                       input bit clr_exec, output int acc_cyc);
    item_t it;
    int n = 0;
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_operand = opnd;
    #1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    acc_cyc = cyc + 1;
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    it.r = r; it.z = z; it.c = c; it.o = o;
    it.cyc = cyc + (ld ? 1 : 2);
    sb.push_back(it);
    $display("cmd load=%b op=%b operand=%b accept_cycle=%0d", ld, op, opnd, acc_cyc);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (clr_exec) begin
      clr_sticky = 1'b1;
      @(negedge clk);
      clr_sticky = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while ((rsp_valid || !cmd_ready) && n < 50);
    if (n >= 50) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int ac, hc;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_acc", acc, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_sticky", {sticky_carry, sticky_ovf}, 0);
    chk("reset_alu_drive", {alu_a, alu_b, alu_op}, 0);
    chk("reset_rsp_data", {rsp_result, rsp_zero, rsp_carry, rsp_overflow}, 0);

    // Load 0010, ADD 0011
    issue(1, 3'b000, 4'b0010, 4'b0010, 0, 0, 0, 0, ac); wait_idle();
    issue(0, ALU_ADD, 4'b0011, 4'b0101, 0, 0, 0, 0, ac); wait_idle();
    chk("add_op_count", op_count, 1);
    chk("add_acc", acc, 4'b0101);
    chk("add_sticky", {sticky_carry, sticky_ovf}, 0);

    // Load 1000, ADD 1000: wrap to zero with carry and overflow
    issue(1, 3'b000, 4'b1000, 4'b1000, 0, 0, 0, 0, ac); wait_idle();
    issue(0, ALU_ADD, 4'b1000, 4'b0000, 1, 1, 1, 0, ac); wait_idle();
    chk("ovf_sticky", {sticky_carry, sticky_ovf}, 2'b11);
    chk("ovf_op_count", op_count, 2);

    clr_sticky = 1'b1; @(negedge clk); clr_sticky = 1'b0; #1;
    chk("clr_sticky_idle", {sticky_carry, sticky_ovf}, 0);

    // Load 0001, SUB 0010 -> borrow; then AND 1100 must not touch sticky
    @(negedge clk);
    issue(1, 3'b000, 4'b0001, 4'b0001, 0, 0, 0, 0, ac); wait_idle();
    issue(0, ALU_SUB, 4'b0010, 4'b1111, 0, 1, 0, 0, ac); wait_idle();
    chk("sub_sticky", {sticky_carry, sticky_ovf}, 2'b10);
    issue(0, ALU_AND, 4'b1100, 4'b1100, 0, 0, 0, 0, ac); wait_idle();
    chk("and_sticky", {sticky_carry, sticky_ovf}, 2'b10);
    chk("and_op_count", op_count, 4);

    // Backpressure: hold rsp_ready low 5 cycles, then back-to-back accept
    rsp_ready = 1'b0;
    issue(0, ALU_ADD, 4'b0001, 4'b1101, 0, 0, 0, 0, ac);
    repeat (5) begin
      @(negedge clk); #1;
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    hc = cyc + 1;
    issue(1, 3'b000, 4'b0111, 4'b0111, 0, 0, 0, 0, ac);
    chk("b2b_accept_cycle", ac, hc);
    wait_idle();
    chk("b2b_acc", acc, 4'b0111);
    chk("b2b_op_count", op_count, 5);

    // Reset while in EXEC drops the pending response
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = ALU_ADD; cmd_operand = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_exec_rsp_valid", rsp_valid, 0);
    chk("rst_exec_acc", acc, 0);
    chk("rst_exec_op_count", op_count, 0);
    chk("rst_exec_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Sticky set, then clear concurrent with an ADD that has carry 0
    issue(1, 3'b000, 4'b1000, 4'b1000, 0, 0, 0, 0, ac); wait_idle();
    issue(0, ALU_ADD, 4'b1000, 4'b0000, 1, 1, 1, 0, ac); wait_idle();
    chk("pre_clr_sticky", {sticky_carry, sticky_ovf}, 2'b11);
    issue(1, 3'b000, 4'b0001, 4'b0001, 0, 0, 0, 0, ac); wait_idle();
    issue(0, ALU_ADD, 4'b0001, 4'b0010, 0, 0, 0, 1, ac); wait_idle();
    chk("clr_with_exec_sticky", {sticky_carry, sticky_ovf}, 0);
    chk("clr_op_count", op_count, 2);

    // Wrap: 254 more ops bring op_count from 2 through 255 to 0
    for (int i = 0; i < 254; i++) begin
      issue(0, ALU_AND, 4'b0000, 4'b0000, 1, 0, 0, 0, ac); wait_idle();
      if (i == 252) chk("count_all_ones", op_count, 255);
    end
    chk("count_wrap", op_count, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
